// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU: FETCH/DECODE/EXEC control FSM, writable program
// store, immediate/carry arithmetic, jumps, and valid/ready IN/OUT handshakes.
//
// state    | meaning
// IDLE     | waiting for start after reset, program store writable
// FETCH    | synchronous read of program store at pc
// DECODE   | latch instruction into ir, advance pc
// EXEC     | execute the instruction in ir
// IN_WAIT  | in_ready high, waiting for in_valid
// OUT_WAIT | out_valid high, out_data held until out_ready
// HALT     | stopped, program store writable, start restarts at pc=0
module acc_cpu_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int OPND_W = 8,
  localparam int INSTR_W = 4 + OPND_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  acc,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halt,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_IN_WAIT, S_OUT_WAIT, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_IN   = 4'h1;
  localparam logic [3:0] OP_OUT  = 4'h2;
  localparam logic [3:0] OP_DEC  = 4'h3;
  localparam logic [3:0] OP_INC  = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_SUBI = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JNZ  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_ILLC = 4'hC;
  localparam logic [3:0] OP_ILLD = 4'hD;
  localparam logic [3:0] OP_ILLE = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [ADDR_W-1:0] PC_ONE  = 1;
  localparam logic [DATA_W-1:0] ACC_ONE = 1;

  state_t state, state_nxt;

  logic [INSTR_W-1:0] mem [2**ADDR_W];
  logic [INSTR_W-1:0] mem_q;
  logic [INSTR_W-1:0] ir;
  logic               c;

  logic [3:0]        opcode;
  logic [DATA_W-1:0] imm;
  logic [ADDR_W-1:0] tgt;
  logic              zero;
  logic              prog_ok;
  logic [DATA_W:0]   sum;

  assign opcode  = ir[INSTR_W-1:OPND_W];
  assign imm     = ir[DATA_W-1:0];
  assign tgt     = ir[ADDR_W-1:0];
  assign zero    = (acc == '0);
  assign prog_ok = (state == S_IDLE) || (state == S_HALT);
  assign sum     = {1'b0, acc} + {1'b0, imm};

  // Store has no reset so its contents survive a reset of the core.
  always_ff @(posedge clock) begin
    if (prog_we && prog_ok)
      mem[prog_addr] <= prog_data;
    if (state == S_FETCH)
      mem_q <= mem[pc];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
      S_FETCH:        state_nxt = S_DECODE;
      S_DECODE:       state_nxt = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_IN:                     state_nxt = S_IN_WAIT;
          OP_OUT:                    state_nxt = S_OUT_WAIT;
          OP_HALT:                   state_nxt = S_HALT;
          OP_ILLC, OP_ILLD, OP_ILLE: state_nxt = S_HALT;
          default:                   state_nxt = S_FETCH;
        endcase
      end
      S_IN_WAIT:  if (in_valid && in_ready) state_nxt = S_FETCH;
      S_OUT_WAIT: if (out_ready) state_nxt = S_FETCH;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      acc       <= '0;
      c         <= 1'b0;
      pc        <= '0;
      ir        <= '0;
      err       <= 1'b0;
      out_data  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      halt      <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != S_IDLE) && (state_nxt != S_HALT);
      halt      <= (state_nxt == S_HALT);
      in_ready  <= (state_nxt == S_IN_WAIT);
      out_valid <= (state_nxt == S_OUT_WAIT);
      case (state)
        S_IDLE: if (start) pc <= '0;
        S_HALT: begin
          if (start) begin
            pc  <= '0;
            err <= 1'b0;
          end
        end
        S_DECODE: begin
          ir <= mem_q;
          pc <= pc + PC_ONE;
        end
        S_EXEC: begin
          // Jump conditions see acc/c before this cycle's update.
          case (opcode)
            OP_NOP:  ;
            OP_OUT:  out_data <= acc;
            OP_DEC:  acc <= acc - ACC_ONE;
            OP_INC:  acc <= acc + ACC_ONE;
            OP_LDI:  acc <= imm;
            OP_ADDI: {c, acc} <= sum;
            OP_SUBI: begin
              acc <= acc - imm;
              c   <= (acc < imm);
            end
            OP_JMP:  pc <= tgt;
            OP_JNZ:  if (!zero) pc <= tgt;
            OP_JZ:   if (zero) pc <= tgt;
            OP_JC:   if (c) pc <= tgt;
            OP_ILLC, OP_ILLD, OP_ILLE: err <= 1'b1;
            default: ;
          endcase
        end
        S_IN_WAIT: if (in_valid && in_ready) acc <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/acc_cpu_param.md
Name: acc_cpu_param

Overview:
Parametrised successor of the 8-bit accumulator microprocessor (control FSM plus datapath). It has configurable data width and program depth, and a writable program store loaded over a port instead of fixed contents. The instruction set is extended with immediates, arithmetic with carry, and conditional/unconditional jumps. IN/OUT ops use valid/ready handshakes so the core stalls on its environment, and illegal-opcode detection is added. It is the top-level compute block: it replaces the fixed microprocessor and its separate datapath/control split.

Parameters:
DATA_W, 8, accumulator and I/O data width (>=2)
ADDR_W, 4, PC / program address width; depth = 2**ADDR_W
OPND_W, 8, instruction operand width; must be >= DATA_W and >= ADDR_W
INSTR_W, 4+OPND_W, instruction width: opcode = [INSTR_W-1:OPND_W], operand = [OPND_W-1:0] (derived, do not override)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; begins execution at PC=0 from IDLE or HALT
prog_we  in  1  program-store write enable
prog_addr  in  ADDR_W  program-store write address
prog_data  in  INSTR_W  program-store write data
in_data  in  DATA_W  input operand for IN
in_valid  in  1  in_data valid
in_ready  out  1  core waiting in IN
out_data  out  DATA_W  OUT value
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data
acc  out  DATA_W  accumulator A
pc  out  ADDR_W  program counter
busy  out  1  high in FETCH/DECODE/EXEC/IN_WAIT/OUT_WAIT
halt  out  1  high in HALT
err  out  1  sticky illegal-opcode flag

Behaviour:
- reset low at a clock edge: state=IDLE; A=0, C=0, PC=0, IR=0, err=0, out_data=0; all handshake outputs 0. The program store is not cleared. This applies identically mid-instruction and mid-handshake.
- Program store: 2**ADDR_W x INSTR_W, synchronous read.
  - Write when prog_we=1 and state is IDLE or HALT.
  - prog_we is ignored in all other states.
- States:
  - IDLE: start -> FETCH with PC=0.
  - FETCH: read addr=PC.
  - DECODE: IR <= mem data; PC <= PC+1, wrapping 2**ADDR_W-1 -> 0.
  - EXEC: perform the op, then return to FETCH unless stated otherwise.
  - A non-stalling instruction takes exactly 3 cycles.
- Opcodes (imm = operand[DATA_W-1:0], tgt = operand[ADDR_W-1:0]):
  - 0 NOP.
  - 1 IN: EXEC -> IN_WAIT. In IN_WAIT, in_ready=1. When in_valid&in_ready: A <= in_data, then FETCH.
  - 2 OUT: EXEC loads out_data <= A and goes to OUT_WAIT. In OUT_WAIT, out_valid=1 and out_data is held stable. When out_ready: FETCH, and out_valid drops the next cycle.
  - 3 DEC: A <= A-1. 4 INC: A <= A+1. Both are mod 2**DATA_W and leave C unchanged.
  - 5 LDI: A <= imm.
  - 6 ADDI: {C,A} <= A+imm (C = carry out).
  - 7 SUBI: A <= A-imm; C = 1 iff A < imm (borrow).
  - 8 JMP: PC <= tgt.
  - 9 JNZ: PC <= tgt if A != 0.
  - A JZ: PC <= tgt if A == 0.
  - B JC: PC <= tgt if C == 1.
  - F HALT: -> HALT.
  - C, D, E are illegal: err <= 1, -> HALT.
- Jump conditions use A/C values at EXEC, before any update. Operand bits above DATA_W/ADDR_W are ignored.
- HALT: PC holds. start -> FETCH with PC=0; A and C are preserved; err is cleared on start.
- start is ignored while busy. start together with prog_we in IDLE/HALT: the write completes and execution begins. The first fetch reads the new data if prog_addr==0.
- Zero condition is derived combinationally from A. Outputs acc and pc are registered values.

Test Plan:
- Countdown: load {LDI 3, OUT, DEC, JNZ 1, HALT}, out_ready=1, start -> out_data sequence 3,2,1; halt=1 with acc=0, pc=5, err=0.
- IN stall: {IN, OUT, HALT}; hold in_valid=0 for 10 cycles, then in_data=0x5A -> in_ready high throughout the wait; A=0x5A; out_data=0x5A.
- OUT backpressure: out_ready=0 for 7 cycles -> out_valid held and out_data stable. PC does not advance until the out_ready cycle.
- Carry: {LDI 0xFF, ADDI 1, JC 5, ..., [5] HALT} -> acc=0, C=1, PC lands at 5. SUBI 1 from 0 gives acc=0xFF, C=1.
- Illegal/wrap: opcode 0xC -> halt=1, err=1, and a subsequent start clears err. With NOPs filling all 16 slots, PC wraps 15->0 with no halt.
- Reset/program guard:
  - reset low during OUT_WAIT -> next cycle IDLE, out_valid=0, acc=0; program contents intact on re-start.
  - prog_we while busy -> store unchanged.
